// File: rtl/ex_alu_stage_if.sv
// Request/response bundle between the ALU control decoder, the EX stage and the EX/MEM latch.
// Inputs to the stage are i_*, outputs o_*; the master side drives requests and observes results.
interface ex_alu_stage_if #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_OP   = 4
);
  logic               i_valid;
  logic               o_ready;
  logic [NB_OP-1:0]   i_alu_op;
  logic               i_shamt_sel;
  logic [4:0]         i_shamt;
  logic [NB_DATA-1:0] i_data_a;
  logic [NB_DATA-1:0] i_data_b;
  logic [NB_REG-1:0]  i_rd_addr;
  logic               i_stall;
  logic               i_flush;
  logic               o_valid;
  logic [NB_DATA-1:0] o_result;
  logic [NB_REG-1:0]  o_rd_addr;
  logic               o_zero;
  logic               o_overflow;
  logic               o_illegal;
  logic               o_busy;

  modport master (
    output i_valid, i_alu_op, i_shamt_sel, i_shamt, i_data_a, i_data_b, i_rd_addr, i_stall, i_flush,
    input  o_ready, o_valid, o_result, o_rd_addr, o_zero, o_overflow, o_illegal, o_busy
  );

  modport slave (
    input  i_valid, i_alu_op, i_shamt_sel, i_shamt, i_data_a, i_data_b, i_rd_addr, i_stall, i_flush,
    output o_ready, o_valid, o_result, o_rd_addr, o_zero, o_overflow, o_illegal, o_busy
  );
endinterface

// File: rtl/ex_alu_stage.sv
// EX-stage ALU with EX/MEM output latch (valid/stall/flush control).
// Define SERIAL_SHIFT_EN to replace the barrel shifter with a one-bit-per-cycle serial shifter FSM.
module ex_alu_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_OP   = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  ex_alu_stage_if.slave    io_bus
);

  localparam logic [NB_OP-1:0] OP_ADD = 4'b0000;
  localparam logic [NB_OP-1:0] OP_SUB = 4'b0001;
  localparam logic [NB_OP-1:0] OP_AND = 4'b0010;
  localparam logic [NB_OP-1:0] OP_OR  = 4'b0011;
  localparam logic [NB_OP-1:0] OP_NOR = 4'b0100;
  localparam logic [NB_OP-1:0] OP_XOR = 4'b0101;
  localparam logic [NB_OP-1:0] OP_SLT = 4'b0111;
  localparam logic [NB_OP-1:0] OP_SLL = 4'b1000;
  localparam logic [NB_OP-1:0] OP_SRL = 4'b1001;
  localparam logic [NB_OP-1:0] OP_SRA = 4'b1011;

  localparam int MSB = NB_DATA - 1;

  logic               r_alive;
  logic               r_valid;
  logic [NB_DATA-1:0] r_result;
  logic [NB_REG-1:0]  r_rd_addr;
  logic               r_zero;
  logic               r_overflow;
  logic               r_illegal;

  logic [4:0]         w_amt;
  logic [NB_DATA-1:0] w_sum;
  logic [NB_DATA-1:0] w_diff;
  logic [NB_DATA-1:0] w_res;
  logic               w_ovf;
  logic               w_ill;
  logic               w_is_shift;
  logic               w_idle;
  logic               w_accept;
  logic               w_complete;
  logic [NB_DATA-1:0] w_out_res;
  logic [NB_REG-1:0]  w_out_rd;
  logic               w_out_ovf;
  logic               w_out_ill;

  assign w_amt    = io_bus.i_shamt_sel ? io_bus.i_shamt : io_bus.i_data_a[4:0];
  assign w_sum    = io_bus.i_data_a + io_bus.i_data_b;
  assign w_diff   = io_bus.i_data_a - io_bus.i_data_b;
  assign w_accept = io_bus.i_valid & io_bus.o_ready;

  assign io_bus.o_ready = r_alive & ~io_bus.i_stall & w_idle;

  // Single-cycle ALU function; in serial mode shifts here only cover amt==0 (result = b).
  always_comb begin
    w_res      = {NB_DATA{1'b0}};
    w_ovf      = 1'b0;
    w_ill      = 1'b0;
    w_is_shift = 1'b0;
    case (io_bus.i_alu_op)
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (io_bus.i_data_a[MSB] == io_bus.i_data_b[MSB]) && (w_sum[MSB] != io_bus.i_data_a[MSB]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (io_bus.i_data_a[MSB] != io_bus.i_data_b[MSB]) && (w_diff[MSB] != io_bus.i_data_a[MSB]);
      end
      OP_AND: w_res = io_bus.i_data_a & io_bus.i_data_b;
      OP_OR:  w_res = io_bus.i_data_a | io_bus.i_data_b;
      OP_NOR: w_res = ~(io_bus.i_data_a | io_bus.i_data_b);
      OP_XOR: w_res = io_bus.i_data_a ^ io_bus.i_data_b;
      OP_SLT: w_res = {{(NB_DATA-1){1'b0}}, ($signed(io_bus.i_data_a) < $signed(io_bus.i_data_b))};
`ifdef SERIAL_SHIFT_EN
      OP_SLL, OP_SRL, OP_SRA: begin
        w_is_shift = 1'b1;
        w_res      = io_bus.i_data_b;
      end
`else
      OP_SLL: begin
        w_is_shift = 1'b1;
        w_res      = io_bus.i_data_b << w_amt;
      end
      OP_SRL: begin
        w_is_shift = 1'b1;
        w_res      = io_bus.i_data_b >> w_amt;
      end
      OP_SRA: begin
        w_is_shift = 1'b1;
        w_res      = $signed(io_bus.i_data_b) >>> w_amt;
      end
`endif
      default: w_ill = 1'b1;
    endcase
  end

`ifdef SERIAL_SHIFT_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [4:0]         r_cnt;
  logic [NB_DATA-1:0] r_sh_data;
  logic [NB_OP-1:0]   r_sh_op;
  logic [NB_REG-1:0]  r_sh_rd;
  logic               w_start;
  logic               w_done;

  function automatic logic [NB_DATA-1:0] f_shift1(input logic [NB_DATA-1:0] d, input logic [NB_OP-1:0] op);
    case (op)
      OP_SLL:  f_shift1 = {d[MSB-1:0], 1'b0};
      OP_SRL:  f_shift1 = {1'b0, d[MSB:1]};
      default: f_shift1 = {d[MSB], d[MSB:1]};
    endcase
  endfunction

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: a flush always returns to IDLE, discarding any partial shift.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_shift && (w_amt != 5'd0)) begin
          w_start      = 1'b1;
          w_state_next = ST_SHIFT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (io_bus.i_stall) begin
          w_state_next = ST_SHIFT;
        end else if (r_cnt == 5'd1) begin
          w_done       = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_SHIFT;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (io_bus.i_flush) begin
      w_state_next = ST_IDLE;
    end else begin
      w_state_next = w_state_next;
    end
  end

  // Serial shifter datapath; frozen while stalled.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt     <= 5'd0;
      r_sh_data <= {NB_DATA{1'b0}};
      r_sh_op   <= {NB_OP{1'b0}};
      r_sh_rd   <= {NB_REG{1'b0}};
    end else if (w_start) begin
      r_cnt     <= w_amt;
      r_sh_data <= io_bus.i_data_b;
      r_sh_op   <= io_bus.i_alu_op;
      r_sh_rd   <= io_bus.i_rd_addr;
    end else if ((r_state == ST_SHIFT) && !io_bus.i_stall) begin
      r_cnt     <= r_cnt - 5'd1;
      r_sh_data <= f_shift1(r_sh_data, r_sh_op);
    end
  end

  assign w_idle        = (r_state == ST_IDLE);
  assign io_bus.o_busy = (r_state == ST_SHIFT);

  // Latch source: the last serial step, or a single-cycle op accepted this edge.
  always_comb begin
    w_complete = 1'b0;
    w_out_res  = w_res;
    w_out_rd   = io_bus.i_rd_addr;
    w_out_ovf  = w_ovf;
    w_out_ill  = w_ill;
    if (w_done) begin
      w_complete = 1'b1;
      w_out_res  = f_shift1(r_sh_data, r_sh_op);
      w_out_rd   = r_sh_rd;
      w_out_ovf  = 1'b0;
      w_out_ill  = 1'b0;
    end else begin
      w_complete = w_accept & ~w_start;
    end
  end
`else
  assign w_idle        = 1'b1;
  assign io_bus.o_busy = 1'b0;
  assign w_complete    = w_accept;
  assign w_out_res     = w_res;
  assign w_out_rd      = io_bus.i_rd_addr;
  assign w_out_ovf     = w_ovf;
  assign w_out_ill     = w_ill;
`endif

  // o_ready stays low until the first edge after reset release.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
    end
  end

  // EX/MEM latch: flush > stall > completion > bubble.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid    <= 1'b0;
      r_result   <= {NB_DATA{1'b0}};
      r_rd_addr  <= {NB_REG{1'b0}};
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (io_bus.i_flush) begin
      r_valid <= 1'b0;
    end else if (io_bus.i_stall) begin
      r_valid <= r_valid;
    end else if (w_complete) begin
      r_valid    <= 1'b1;
      r_result   <= w_out_res;
      r_rd_addr  <= w_out_rd;
      r_zero     <= (w_out_res == {NB_DATA{1'b0}});
      r_overflow <= w_out_ovf;
      r_illegal  <= w_out_ill;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign io_bus.o_valid    = r_valid;
  assign io_bus.o_result   = r_result;
  assign io_bus.o_rd_addr  = r_rd_addr;
  assign io_bus.o_zero     = r_zero;
  assign io_bus.o_overflow = r_overflow;
  assign io_bus.o_illegal  = r_illegal;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Bench for ex_alu_stage: op-table model with cycle-level latch behaviour, compared every cycle,
// plus directed vectors with literal expectations. Honours SERIAL_SHIFT_EN like the design.
module tb_ex_alu_stage;

`ifdef SERIAL_SHIFT_EN
  localparam bit SERIAL = 1'b1;
`else
  localparam bit SERIAL = 1'b0;
`endif
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_alu_stage_if #(.NB_DATA(32), .NB_REG(5), .NB_OP(4)) bus();

  ex_alu_stage #(.NB_DATA(32), .NB_REG(5), .NB_OP(4)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .io_bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        ill;
    logic        shift;
  } gold_t;

  // Op table straight from the opcode list, using wide signed arithmetic for overflow.
  function automatic gold_t golden(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] amt);
    gold_t  g;
    longint s;
    g = '0;
    case (op)
      4'd0: begin
        s = longint'($signed(a)) + longint'($signed(b));
        g.res = a + b; g.ovf = (s > SMAX) || (s < SMIN);
      end
      4'd1: begin
        s = longint'($signed(a)) - longint'($signed(b));
        g.res = a - b; g.ovf = (s > SMAX) || (s < SMIN);
      end
      4'd2: g.res = a & b;
      4'd3: g.res = a | b;
      4'd4: g.res = ~(a | b);
      4'd5: g.res = a ^ b;
      4'd7: g.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8: begin g.res = b << amt; g.shift = 1'b1; end
      4'd9: begin g.res = b >> amt; g.shift = 1'b1; end
      4'd11: begin g.res = $signed(b) >>> amt; g.shift = 1'b1; end
      default: g.ill = 1'b1;
    endcase
    return g;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state
  logic        m_alive, m_valid, m_ovf, m_ill, m_pend;
  logic [31:0] m_res, p_res;
  logic [4:0]  m_rd, p_rd;
  int          m_left;

  always @(posedge clk or negedge rst_n) begin : model
    gold_t      g;
    logic       acc;
    logic [4:0] amt;
    if (!rst_n) begin
      m_alive <= 1'b0; m_valid <= 1'b0; m_res <= 32'd0; m_rd <= 5'd0;
      m_ovf <= 1'b0; m_ill <= 1'b0; m_pend <= 1'b0; m_left <= 0;
      p_res <= 32'd0; p_rd <= 5'd0;
    end else begin
      m_alive <= 1'b1;
      amt = bus.i_shamt_sel ? bus.i_shamt : bus.i_data_a[4:0];
      g   = golden(bus.i_alu_op, bus.i_data_a, bus.i_data_b, amt);
      acc = bus.i_valid && m_alive && !bus.i_stall && !m_pend;
      if (bus.i_flush) begin
        m_valid <= 1'b0; m_pend <= 1'b0;
      end else if (bus.i_stall) begin
        m_left <= m_left;
      end else if (m_pend) begin
        if (m_left == 1) begin
          m_valid <= 1'b1; m_res <= p_res; m_rd <= p_rd; m_ovf <= 1'b0; m_ill <= 1'b0; m_pend <= 1'b0;
        end else begin
          m_valid <= 1'b0; m_left <= m_left - 1;
        end
      end else if (acc) begin
        if (SERIAL && g.shift && (amt != 5'd0)) begin
          m_pend <= 1'b1; m_left <= int'(amt); p_res <= g.res; p_rd <= bus.i_rd_addr; m_valid <= 1'b0;
        end else begin
          m_valid <= 1'b1; m_res <= g.res; m_rd <= bus.i_rd_addr; m_ovf <= g.ovf; m_ill <= g.ill;
        end
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("valid", {31'd0, bus.o_valid}, {31'd0, m_valid});
    chk("ready", {31'd0, bus.o_ready}, {31'd0, m_alive && !bus.i_stall && !m_pend});
    chk("busy",  {31'd0, bus.o_busy},  {31'd0, m_pend});
    if (m_valid) begin
      chk("result",   bus.o_result, m_res);
      chk("rd_addr",  {27'd0, bus.o_rd_addr}, {27'd0, m_rd});
      chk("zero",     {31'd0, bus.o_zero}, {31'd0, m_res == 32'd0});
      chk("overflow", {31'd0, bus.o_overflow}, {31'd0, m_ovf});
      chk("illegal",  {31'd0, bus.o_illegal}, {31'd0, m_ill});
    end
  end

  task automatic drive(input logic v, input logic [3:0] op, input logic sel, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic st, input logic fl);
    bus.i_valid = v; bus.i_alu_op = op; bus.i_shamt_sel = sel; bus.i_shamt = sh;
    bus.i_data_a = a; bus.i_data_b = b; bus.i_rd_addr = rd; bus.i_stall = st; bus.i_flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!bus.o_valid && k < 40) begin
      idle();
      k++;
    end
    if (!bus.o_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: o_valid still 0 after 40 cycles", name);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_valid = 1'b0; bus.i_alu_op = 4'd0; bus.i_shamt_sel = 1'b0; bus.i_shamt = 5'd0;
    bus.i_data_a = 32'd0; bus.i_data_b = 32'd0; bus.i_rd_addr = 5'd0; bus.i_stall = 1'b0; bus.i_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_result", bus.o_result, 32'd0);
    chk("rst_ready", {31'd0, bus.o_ready}, 32'd0);
    chk("rst_flags", {27'd0, bus.o_zero, bus.o_overflow, bus.o_illegal, bus.o_busy, 1'b0}, 32'd0);
    chk("rst_rd", {27'd0, bus.o_rd_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", {31'd0, bus.o_ready}, 32'd1);

    drive(1'b1, 4'd0, 1'b0, 5'd0, 32'h7FFFFFFF, 32'h1, 5'd3, 1'b0, 1'b0);
    chk("add_ovf_res", bus.o_result, 32'h80000000);
    chk("add_ovf_flag", {30'd0, bus.o_overflow, bus.o_zero}, 32'd2);
    drive(1'b1, 4'd1, 1'b0, 5'd0, 32'd5, 32'd5, 5'd4, 1'b0, 1'b0);
    chk("sub_zero", {bus.o_result[30:0], bus.o_zero}, 32'd1);

    drive(1'b1, 4'd11, 1'b1, 5'd4, 32'd0, 32'hF0000000, 5'd5, 1'b0, 1'b0);
    wait_valid("sra");
    chk("sra_res", bus.o_result, 32'hFF000000);
    drive(1'b1, 4'd8, 1'b0, 5'd0, 32'h24, 32'h1, 5'd6, 1'b0, 1'b0);
    wait_valid("sllv");
    chk("sllv_res", bus.o_result, 32'h00000010);

    drive(1'b1, 4'd15, 1'b0, 5'd0, 32'h1234, 32'h5678, 5'd7, 1'b0, 1'b0);
    chk("illegal_f", {bus.o_result[29:0], bus.o_illegal, bus.o_valid}, 32'd3);
    drive(1'b1, 4'd7, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h1, 5'd8, 1'b0, 1'b0);
    chk("slt_neg", bus.o_result, 32'd1);
    drive(1'b1, 4'd7, 1'b0, 5'd0, 32'h1, 32'hFFFFFFFF, 5'd8, 1'b0, 1'b0);
    chk("slt_pos", bus.o_result, 32'd0);
    drive(1'b1, 4'd0, 1'b0, 5'd0, 32'h80000000, 32'hFFFFFFFF, 5'd9, 1'b0, 1'b0);
    chk("add_negovf", {bus.o_result[31:1], bus.o_overflow}, 32'h7FFFFFFF);
    drive(1'b1, 4'd1, 1'b0, 5'd0, 32'h80000000, 32'h1, 5'd9, 1'b0, 1'b0);
    chk("sub_ovf", {31'd0, bus.o_overflow}, 32'd1);
    drive(1'b1, 4'd4, 1'b0, 5'd0, 32'hF0F0F0F0, 32'h0F0F0F00, 5'd10, 1'b0, 1'b0);
    chk("nor", bus.o_result, 32'h000000F0 ^ 32'h000000F0 | 32'h0000000F);
    drive(1'b1, 4'd9, 1'b0, 5'd0, 32'h0, 32'h80000001, 5'd11, 1'b0, 1'b0);
    chk("srl_amt0", bus.o_result, 32'h80000001);
    drive(1'b1, 4'd13, 1'b0, 5'd0, 32'h1, 32'h1, 5'd12, 1'b0, 1'b0);
    chk("illegal_d", {31'd0, bus.o_illegal}, 32'd1);

    // Stall after a result, then flush while still stalled.
    drive(1'b1, 4'd0, 1'b0, 5'd0, 32'd1, 32'd2, 5'd13, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd1, 1'b0, 5'd0, 32'd9, 32'd4, 5'd14, 1'b1, 1'b0);
      chk("stall_hold", {bus.o_result[29:0], bus.o_valid, bus.o_ready}, 32'd14);
    end
    drive(1'b0, 4'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    chk("flush_valid", {31'd0, bus.o_valid}, 32'd0);
    idle();
    chk("ready_after_flush", {31'd0, bus.o_ready}, 32'd1);

    // SLL by 3: serial takes amt+1 edges; barrel completes at once.
    drive(1'b1, 4'd8, 1'b1, 5'd3, 32'd0, 32'd5, 5'd15, 1'b0, 1'b0);
`ifdef SERIAL_SHIFT_EN
    for (int i = 0; i < 3; i++) begin
      chk("ser_busy", {30'd0, bus.o_busy, bus.o_valid}, 32'd2);
      idle();
    end
    chk("ser_done", {bus.o_result[30:0], bus.o_valid}, 32'h51);
    drive(1'b1, 4'd8, 1'b1, 5'd3, 32'd0, 32'd5, 5'd15, 1'b0, 1'b0);
    idle();
    drive(1'b0, 4'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    chk("ser_flush", {29'd0, bus.o_valid, bus.o_busy, bus.o_ready}, 32'd1);
    repeat (4) begin
      idle();
      chk("ser_flush_quiet", {31'd0, bus.o_valid}, 32'd0);
    end
`else
    chk("bar_sll", {bus.o_result[29:0], bus.o_busy, bus.o_valid}, 32'hA1);
`endif

    // Mixed vectors with occasional stall/flush; checked by the model each cycle.
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 4'(i % 16), 1'(i % 2), 5'($urandom_range(31, 0)), $urandom, $urandom, 5'(i),
            1'(i % 7 == 3), 1'(i % 11 == 5));
    end
    repeat (40) idle();

    drive(1'b1, 4'd2, 1'b0, 5'd0, 32'hFF, 32'h0F, 5'd1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst", {bus.o_result[27:0], bus.o_valid, bus.o_busy, bus.o_ready, bus.o_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
